issue_ctrl: RTL
===============

Name: issue_ctrl

Overview:
- Scoreboard-based issue controller sitting between decode and execute.
- Stalls the decoded instruction on RAW/WAW hazards against in-flight register writes.
- Limits the number of in-flight register writers, drains the pipeline for fence-type instructions, and handles one-cycle flushes.
- Owns the pending-write state for the regfile's 32 architectural registers.

Parameters:
- NUM_REGS, 32, architectural registers; x0 is never pending.
- REG_ADDR_W, 5, register address width (log2 NUM_REGS).
- MAX_INFLIGHT, 4, maximum issued-but-not-written-back register writers.
- CNT_W, 3, in-flight counter width (log2(MAX_INFLIGHT)+1).

Ports:
- clk_i in 1: clock.
- rstn_i in 1: synchronous active-low reset.
- dec_valid_i in 1: decode holds a valid instruction.
- dec_ready_o out 1: decode instruction consumed this cycle.
- dec_rs1_addr_i in REG_ADDR_W: rs1 address.
- dec_rs1_used_i in 1: instruction reads rs1.
- dec_rs2_addr_i in REG_ADDR_W: rs2 address.
- dec_rs2_used_i in 1: instruction reads rs2.
- dec_rd_addr_i in REG_ADDR_W: rd address.
- dec_rd_we_i in 1: instruction writes rd.
- dec_fence_i in 1: instruction requires an empty pipeline before issue.
- issue_valid_o out 1: instruction presented to execute.
- issue_ready_i in 1: execute accepts.
- wb_valid_i in 1: writeback retires a register write.
- wb_rd_addr_i in REG_ADDR_W: writeback register.
- flush_i in 1: kill the instruction in decode.
- fetch_stall_o out 1: hold fetch/PC.
- inflight_cnt_o out CNT_W: current in-flight writer count.
- sb_err_o out 1: sticky scoreboard protocol error.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rstn_i is synchronous, active-low, sampled on the rising edge.
- Reset values: pending = 0, cnt = 0, state = RUN, sb_err_o = 0. While rstn_i = 0, issue_valid_o, dec_ready_o and fetch_stall_o are forced to 0.
- States:
  - RUN: normal issue.
  - DRAIN: waiting for cnt = 0 on a fence.
  - FLUSH: single dead cycle.
- hazard = (rs1_used & pending[rs1]) | (rs2_used & pending[rs2]) | (rd_we & rd≠0 & pending[rd]).
  - The hazard check uses registered pending bits only. There is no same-cycle writeback bypass.
  - Consequence: a consumer issues at the earliest one cycle after the wb_valid_i cycle.
- credit_ok = ~dec_rd_we_i | rd = 0 | cnt < MAX_INFLIGHT.
- can_issue = state = RUN & dec_valid_i & ~flush_i & ~hazard & credit_ok & (~dec_fence_i | cnt = 0).
- Handshake:
  - issue_valid_o = can_issue.
  - dec_ready_o = can_issue & issue_ready_i.
  - fire = dec_ready_o.
  - Issue is combinational, with zero added latency when no stall applies.
- fetch_stall_o = dec_valid_i & ~dec_ready_o.
- On fire with rd_we and rd≠0: set pending[rd] and cnt += 1.
- On wb_valid_i with pending[wb_rd] = 1: clear the bit and cnt -= 1.
- Writeback edge cases:
  - wb_valid_i to a non-pending register, or to x0: no state change, sb_err_o set sticky until reset.
  - Simultaneous fire and wb: both applied, so cnt is unchanged when both count.
  - Fire and wb to the same rd cannot coincide, because the WAW hazard blocks it.
- Transitions:
  - RUN → DRAIN: dec_valid_i & dec_fence_i & cnt≠0 & ~flush_i.
  - DRAIN → RUN: cnt = 0. The fence issues at the earliest in the next RUN cycle.
  - Any state → FLUSH: flush_i = 1. flush_i has priority over all other transitions.
  - FLUSH → RUN: always, after one cycle.
- Flush:
  - Pending bits and cnt are unaffected by flush. In-flight writes still retire during flush and are tracked normally.
  - Flush in DRAIN abandons the drain.
- While issue_ready_i = 0, the decoded instruction is held by decode (fetch_stall_o = 1). No internal buffering.

Decomposition:
- tartaruga_pkg additions:
  - issue_state_t enum {RUN, DRAIN, FLUSH}.
  - reg_addr_t (REG_ADDR_W bits).
  - NUM_REGS and MAX_INFLIGHT constants.
- One sub-module, scoreboard:
  - Holds the pending vector and cnt.
  - Inputs: set/clear requests.
  - Outputs: pending bits, cnt, error pulse.
- issue_ctrl keeps the FSM, hazard/credit logic and handshake.

Test Plan:
1. Reset then independent stream (rd x1..x4, no sources), issue_ready_i = 1 → one fire per cycle; inflight_cnt_o reaches 4; a fifth writer (x5) stalls with fetch_stall_o = 1 until a wb arrives.
2. RAW: fire rd = x5; next instruction rs1 = x5 → issue_valid_o = 0 until wb_valid_i(x5) at cycle T; issues at T+1, not T.
3. WAW plus simultaneous events: pending x7; instruction with rd = x7 stalls; wb x3 and a fire to x9 in the same cycle → cnt unchanged, pending[3] = 0, pending[9] = 1.
4. Fence with cnt = 2 → state DRAIN, dec_ready_o = 0; after two wbs cnt = 0, state RUN, fence fires the following cycle.
5. flush_i during DRAIN with cnt = 1 → one FLUSH cycle with no issue, then RUN; pending bit remains; a later wb clears it, cnt = 0.
6. wb_valid_i to non-pending x10, and separately to x0 → sb_err_o = 1 and stays high; pending and cnt unchanged; rd = x0 writers never set a bit; rstn_i low mid-stall clears everything within one cycle.

Source files
------------

// File: rtl/tartaruga_pkg.sv
// rtl/tartaruga_pkg.sv - shared types and constants for the issue controller
// Provides: NUM_REGS, REG_ADDR_W, MAX_INFLIGHT, CNT_W, reg_addr_t, issue_state_t
package tartaruga_pkg;

    localparam int NUM_REGS     = 32;
    localparam int REG_ADDR_W   = 5;
    localparam int MAX_INFLIGHT = 4;
    localparam int CNT_W        = 3;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } issue_state_t;

endpackage

// File: rtl/issue_ctrl_scoreboard.sv
// rtl/issue_ctrl_scoreboard.sv - pending-write bits and in-flight writer count
// Ports:
//   clk_i, rstn_i         : clock, synchronous active-low reset
//   set_valid_i/set_addr_i: an issued writer claims a register
//   clr_valid_i/clr_addr_i: writeback retires a register write
//   pending_o             : registered pending bit per architectural register
//   cnt_o                 : number of pending registers
//   err_o                 : one-cycle pulse on a writeback to x0 or a non-pending register
module issue_ctrl_scoreboard
    import tartaruga_pkg::*;
(
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                set_valid_i,
    input  reg_addr_t           set_addr_i,
    input  logic                clr_valid_i,
    input  reg_addr_t           clr_addr_i,
    output logic [NUM_REGS-1:0] pending_o,
    output logic [CNT_W-1:0]    cnt_o,
    output logic                err_o
);

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                set_hit, clr_hit;

    always_comb begin
        // x0 is hardwired zero, so it is never claimed and never legitimately retired.
        set_hit = set_valid_i && (set_addr_i != '0);
        clr_hit = clr_valid_i && (clr_addr_i != '0) && pending_q[clr_addr_i];
        err_o   = clr_valid_i && !clr_hit;

        pending_d = pending_q;
        if (set_hit) pending_d[set_addr_i] = 1'b1;
        if (clr_hit) pending_d[clr_addr_i] = 1'b0;

        // Set and clear on the same cycle leave the count unchanged.
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, set_hit} - {{(CNT_W-1){1'b0}}, clr_hit};
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign pending_o = pending_q;
    assign cnt_o     = cnt_q;

endmodule

// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - scoreboard-based issue controller between decode and execute
// Ports:
//   clk_i, rstn_i      : clock, synchronous active-low reset
//   dec_*              : decoded instruction (valid, sources, destination, fence) and consume strobe
//   issue_valid_o/issue_ready_i : handshake towards execute
//   wb_valid_i/wb_rd_addr_i     : register write retirement
//   flush_i            : kill the instruction in decode
//   fetch_stall_o      : hold fetch while decode is occupied but not consumed
//   inflight_cnt_o     : issued-but-not-retired register writers
//   sb_err_o           : sticky writeback protocol error
module issue_ctrl
    import tartaruga_pkg::*;
(
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             dec_valid_i,
    output logic             dec_ready_o,
    input  reg_addr_t        dec_rs1_addr_i,
    input  logic             dec_rs1_used_i,
    input  reg_addr_t        dec_rs2_addr_i,
    input  logic             dec_rs2_used_i,
    input  reg_addr_t        dec_rd_addr_i,
    input  logic             dec_rd_we_i,
    input  logic             dec_fence_i,
    output logic             issue_valid_o,
    input  logic             issue_ready_i,
    input  logic             wb_valid_i,
    input  reg_addr_t        wb_rd_addr_i,
    input  logic             flush_i,
    output logic             fetch_stall_o,
    output logic [CNT_W-1:0] inflight_cnt_o,
    output logic             sb_err_o
);

    issue_state_t        state_q, state_d;
    logic                sb_err_q, sb_err_d;
    logic [NUM_REGS-1:0] pending;
    logic [CNT_W-1:0]    cnt;
    logic                err_pulse;
    logic                hazard, credit_ok, can_issue;

    issue_ctrl_scoreboard u_sb (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .set_valid_i (dec_ready_o && dec_rd_we_i),
        .set_addr_i  (dec_rd_addr_i),
        .clr_valid_i (wb_valid_i),
        .clr_addr_i  (wb_rd_addr_i),
        .pending_o   (pending),
        .cnt_o       (cnt),
        .err_o       (err_pulse)
    );

    // Registered pending bits only: a consumer of a retiring register waits one
    // extra cycle rather than adding a writeback bypass onto the issue path.
    always_comb begin
        hazard = (dec_rs1_used_i && pending[dec_rs1_addr_i])
               || (dec_rs2_used_i && pending[dec_rs2_addr_i])
               || (dec_rd_we_i && (dec_rd_addr_i != '0) && pending[dec_rd_addr_i]);

        credit_ok = !dec_rd_we_i || (dec_rd_addr_i == '0) || (cnt < CNT_W'(MAX_INFLIGHT));

        can_issue = rstn_i && (state_q == RUN) && dec_valid_i && !flush_i && !hazard
                  && credit_ok && (!dec_fence_i || (cnt == '0));

        issue_valid_o = can_issue;
        dec_ready_o   = can_issue && issue_ready_i;
        fetch_stall_o = rstn_i && dec_valid_i && !dec_ready_o;
    end

    always_comb begin
        state_d  = state_q;
        sb_err_d = sb_err_q || err_pulse;
        if (flush_i) begin
            state_d = FLUSH;
        end else begin
            unique case (state_q)
                RUN:     if (dec_valid_i && dec_fence_i && (cnt != '0)) state_d = DRAIN;
                DRAIN:   if (cnt == '0) state_d = RUN;
                FLUSH:   state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q  <= RUN;
            sb_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sb_err_q <= sb_err_d;
        end
    end

    assign inflight_cnt_o = cnt;
    assign sb_err_o       = sb_err_q;

endmodule
